// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state codes and datapath mux encodings
// for the multicycle MIPS control path. Types and constants only.
// No timing or flow control of its own.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_NONE, CLS_RTYPE, CLS_LW, CLS_SW, CLS_ADDI, CLS_BEQ, CLS_J
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        logic         valid;
    } dec_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Classifies opcode/funct into an instruction class plus a valid flag.
// Purely combinational, zero cycles.
// No flow control.
module instr_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec = '{cls: CLS_NONE, valid: 1'b0};
        case (opcode)
            OP_RTYPE: begin
                if (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})
                    dec = '{cls: CLS_RTYPE, valid: 1'b1};
            end
            OP_LW:    dec = '{cls: CLS_LW,   valid: 1'b1};
            OP_SW:    dec = '{cls: CLS_SW,   valid: 1'b1};
            OP_ADDI:  dec = '{cls: CLS_ADDI, valid: 1'b1};
            OP_BEQ:   dec = '{cls: CLS_BEQ,  valid: 1'b1};
            OP_J:     dec = '{cls: CLS_J,    valid: 1'b1};
            default:  dec = '{cls: CLS_NONE, valid: 1'b0};
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath.
// 3-5 cycles per instruction, plus one per cycle mem_ready is low in a memory state.
// Memory states stall on mem_ready (ignored when MEM_WAIT_EN=0).
module multicycle_control
    import mips_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal,
    output logic [3:0] state
);

    state_t cur_state, nxt_state;
    dec_t   dec;
    ctrl_t  ctrl;
    logic   rdy;

    assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

    instr_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur_state <= S_FETCH;
        else       cur_state <= nxt_state;
    end

    always_comb begin
        ctrl      = '0;
        nxt_state = cur_state;
        case (cur_state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                if (rdy) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    nxt_state     = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
                // Unsupported encodings drop straight back to FETCH with only the flag raised.
                if (!dec.valid) begin
                    ctrl.illegal = 1'b1;
                    nxt_state    = S_FETCH;
                end else begin
                    case (dec.cls)
                        CLS_LW, CLS_SW: nxt_state = S_MEM_ADDR;
                        CLS_RTYPE:      nxt_state = S_R_EXEC;
                        CLS_ADDI:       nxt_state = S_ADDI_EXEC;
                        CLS_BEQ:        nxt_state = S_BRANCH;
                        CLS_J:          nxt_state = S_JUMP;
                        default:        nxt_state = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                if (dec.cls == CLS_SW)      nxt_state = S_MEM_WRITE;
                else if (dec.cls == CLS_LW) nxt_state = S_MEM_READ;
                else                        nxt_state = S_FETCH;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (rdy) nxt_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                nxt_state       = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (rdy) nxt_state = S_FETCH;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
                nxt_state      = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                nxt_state      = S_FETCH;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                nxt_state      = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                nxt_state      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
                nxt_state          = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
                nxt_state      = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH; strobes stay quiet until reset is released.
    assign pc_write      = ctrl.pc_write  & ~reset;
    assign ir_write      = ctrl.ir_write  & ~reset;
    assign reg_write     = ctrl.reg_write & ~reset;
    assign mem_write     = ctrl.mem_write & ~reset;
    assign illegal       = ctrl.illegal   & ~reset;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state         = cur_state;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1: when 1, memory states wait for mem_ready; when 0, mem_ready is treated as constant 1.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  input  6  IR[31:26], valid from DECODE onward.
REQ-005 SHALL have port funct  input  6  IR[5:0].
REQ-006 SHALL have port mem_ready  input  1  memory has completed the current read or write this cycle.
REQ-007 SHALL have ports pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, each output  1.
REQ-008 SHALL have ports alu_src_b  output  2  (00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2).
REQ-009 SHALL have port alu_op  output  2  (00 add, 01 sub, 10 decode funct).
REQ-010 SHALL have port pc_source  output  2  (00 ALU result, 01 ALUOut, 10 jump target).
REQ-011 SHALL have ports illegal  output  1  one-cycle pulse on an unsupported instruction, and state  output  4  current state code for debug.

Function
REQ-012 SHALL implement a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP; all outputs are decoded from state and mem_ready only.
REQ-013 SHALL decode the supported set as: R-type (opcode 000000) with funct add 100000, sub 100010, and 100100, or 100101, slt 101010; lw 100011; sw 101011; addi 001000; beq 000100; j 000010.
REQ-014 FETCH SHALL assert mem_read, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL assert only in a cycle with mem_ready=1, and the FSM then moves to DECODE, otherwise it holds FETCH.
REQ-015 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute), then branch: lw/sw->MEM_ADDR, R-type->R_EXEC, addi->ADDI_EXEC, beq->BRANCH, j->JUMP.
REQ-016 An unsupported opcode, or an R-type with unsupported funct, SHALL pulse illegal in DECODE and return to FETCH with no register, memory or PC side effect.
REQ-017 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_READ for lw or MEM_WRITE for sw.
REQ-018 MEM_READ SHALL assert mem_read with i_or_d=1 and hold until mem_ready, then go to MEM_WB; MEM_WB SHALL assert reg_write with mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-019 MEM_WRITE SHALL assert mem_write with i_or_d=1 and hold until mem_ready, then go to FETCH.
REQ-020 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10; R_WB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-021 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; ADDI_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0.
REQ-022 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; JUMP SHALL drive pc_write=1 and pc_source=10; both then go to FETCH.
REQ-023 With mem_ready held at 1, latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each cycle of mem_ready=0 in a memory state SHALL add exactly one cycle.
REQ-024 Every output not listed for a state SHALL be 0; mem_read and mem_write SHALL never be asserted together.

Reset
REQ-025 Asserting reset SHALL force state FETCH immediately and asynchronously, including mid-instruction, with pc_write, ir_write, reg_write, mem_write and illegal at 0 until the first post-reset edge.
REQ-026 After reset deasserts, the first rising edge SHALL evaluate FETCH normally; an aborted store SHALL not be retried.

Structure
REQ-027 The opcode and funct constants, the state enumeration, and the alu_src_b, alu_op and pc_source encodings SHALL live in a shared package, mips_pkg.
REQ-028 The block SHALL contain one sub-module, instr_decode, which is combinational and maps opcode and funct to an instruction class plus a valid flag.

Verification
REQ-029 The bench SHALL cover: add (opcode 0, funct 100000) with mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB; reg_write=1 and reg_dst=1 in cycle 4 only.
REQ-030 The bench SHALL cover: lw (100011) with mem_ready low for 2 cycles in MEM_READ -> total 7 cycles; reg_write=1 with mem_to_reg=1 in the last cycle.
REQ-031 The bench SHALL cover: opcode 111111, then R-type funct 000111 -> illegal pulses once in DECODE for each, the next state is FETCH, and no write strobe asserts.
REQ-032 The bench SHALL cover: beq (000100) -> pc_write_cond=1 with pc_source=01 in cycle 3; j (000010) -> pc_write=1 with pc_source=10 in cycle 3.
REQ-033 The bench SHALL cover: reset asserted in MEM_WRITE while mem_ready=0 -> state=FETCH and mem_write=0 before the next clock edge.
REQ-034 The bench SHALL cover: MEM_WAIT_EN=0 with mem_ready tied to 0 -> sw completes in 4 cycles.
